// File: rtl/wb_mon_pkg.sv
// Shared constants and helpers for the Wishbone B4 pipelined protocol monitor.
// Rule indices double as bit positions in o_violation and as o_first codes.
package wb_mon_pkg;

    localparam int unsigned VIOL_W             = 12;
    localparam int unsigned VIOL_STB_NO_CYC    = 0;
    localparam int unsigned VIOL_REQ_CHANGED   = 1;
    localparam int unsigned VIOL_OPEN_NO_STB   = 2;
    localparam int unsigned VIOL_WR_NO_SEL     = 3;
    localparam int unsigned VIOL_IDLE_CYC      = 4;
    localparam int unsigned VIOL_DISCONT_STB   = 5;
    localparam int unsigned VIOL_CYC_AFTER_ERR = 6;
    localparam int unsigned VIOL_SPURIOUS_ACK  = 7;
    localparam int unsigned VIOL_ACK_AND_ERR   = 8;
    localparam int unsigned VIOL_STALL_TIMEOUT = 9;
    localparam int unsigned VIOL_ACK_TIMEOUT   = 10;
    localparam int unsigned VIOL_OVERFLOW      = 11;

    typedef logic [3:0] first_t;

    // Lowest set rule index; scanning downwards lets the lowest index win.
    function automatic first_t lowest_viol(input logic [VIOL_W-1:0] v);
        first_t idx = '0;
        for (int i = int'(VIOL_W) - 1; i >= 0; i--) begin
            if (v[i]) idx = first_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_mon_timer.sv
// Consecutive-event counter: expires once the event has held for LIMIT+1 cycles in a row,
// counting the current cycle, and saturates there so a persisting event never wraps.
module wb_mon_timer #(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned WIDTH = 3
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_event,
    output logic o_expired,
    output logic o_rose
);

    localparam logic [WIDTH-1:0] Sat = WIDTH'(LIMIT + 1);
    localparam logic [WIDTH-1:0] Lim = WIDTH'(LIMIT);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             expired_q;

    always_comb begin
        cnt_d = '0;
        if (i_event) begin
            cnt_d = (cnt_q == Sat) ? Sat : cnt_q + 1'b1;
        end
        o_expired = cnt_d > Lim;
        o_rose    = o_expired && !expired_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= o_expired;
        end
    end

endmodule

// File: rtl/wb_protocol_monitor.sv
// Passive Wishbone B4 pipelined-bus monitor: counts requests/acks, latches sticky per-rule
// violation flags plus the first rule broken, and pulses o_abort when a timeout begins.
module wb_protocol_monitor
    import wb_mon_pkg::*;
#(
    parameter int unsigned AW                = 32,
    parameter int unsigned DW                = 32,
    parameter int unsigned LGDEPTH           = 4,
    parameter int unsigned MAX_STALL         = 4,
    parameter int unsigned MAX_ACK_DELAY     = 10,
    parameter bit          OPT_RMW           = 1'b0,
    parameter bit          OPT_DISCONTINUOUS = 1'b0,
    parameter bit          OPT_ABORT         = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stb,
    input  logic                i_wb_we,
    input  logic [AW-1:0]       i_wb_addr,
    input  logic [DW-1:0]       i_wb_data,
    input  logic [DW/8-1:0]     i_wb_sel,
    input  logic                i_wb_ack,
    input  logic                i_wb_stall,
    input  logic                i_wb_err,
    input  logic                i_clear,
    output logic [LGDEPTH-1:0]  o_nreqs,
    output logic [LGDEPTH-1:0]  o_nacks,
    output logic [LGDEPTH-1:0]  o_outstanding,
    output logic [VIOL_W-1:0]   o_violation,
    output first_t              o_first,
    output logic                o_first_valid,
    output logic                o_abort
);

    localparam int unsigned ReqW = 1 + AW + DW + DW / 8;

    logic               past_valid_q, prev_cyc_q, prev_stb_q, prev_stall_q, prev_err_q;
    logic [ReqW-1:0]    req, prev_req_q;
    logic [LGDEPTH-1:0] nreqs_q, nreqs_d, nacks_q, nacks_d, outstanding;
    logic               accept, ack_any;
    logic               stall_expired, stall_rose, ack_expired, ack_rose;
    logic [VIOL_W-1:0]  viol, flags_q, flags_d;
    first_t             first_q, first_d;
    logic               first_valid_q, first_valid_d;

    assign req         = {i_wb_we, i_wb_addr, i_wb_data, i_wb_sel};
    assign accept      = i_wb_cyc && i_wb_stb && !i_wb_stall;
    assign ack_any     = i_wb_cyc && (i_wb_ack || i_wb_err);
    assign outstanding = i_wb_cyc ? (nreqs_q - nacks_q) : '0;

    always_comb begin
        nreqs_d = '0;
        nacks_d = '0;
        if (i_wb_cyc) begin
            nreqs_d = nreqs_q + {{(LGDEPTH-1){1'b0}}, accept};
            nacks_d = nacks_q + {{(LGDEPTH-1){1'b0}}, ack_any};
        end
    end

    generate
        if (MAX_STALL != 0) begin : g_stall_timer
            wb_mon_timer #(
                .LIMIT (MAX_STALL),
                .WIDTH ($clog2(MAX_STALL + 2))
            ) u_stall_timer (
                .i_clk     (i_clk),
                .i_reset   (i_reset),
                .i_event   (i_wb_stb && i_wb_stall),
                .o_expired (stall_expired),
                .o_rose    (stall_rose)
            );
        end else begin : g_no_stall_timer
            assign stall_expired = 1'b0;
            assign stall_rose    = 1'b0;
        end

        if (MAX_ACK_DELAY != 0) begin : g_ack_timer
            wb_mon_timer #(
                .LIMIT (MAX_ACK_DELAY),
                .WIDTH ($clog2(MAX_ACK_DELAY + 2))
            ) u_ack_timer (
                .i_clk     (i_clk),
                .i_reset   (i_reset),
                .i_event   (i_wb_cyc && !i_wb_stb && !i_wb_ack && !i_wb_err
                            && (outstanding != '0)),
                .o_expired (ack_expired),
                .o_rose    (ack_rose)
            );
        end else begin : g_no_ack_timer
            assign ack_expired = 1'b0;
            assign ack_rose    = 1'b0;
        end
    endgenerate

    // Rules on prior-cycle state are gated by past_valid_q so nothing fires just after reset.
    always_comb begin
        viol = '0;
        if (!i_reset) begin
            viol[VIOL_STB_NO_CYC]    = i_wb_stb && !i_wb_cyc;
            viol[VIOL_REQ_CHANGED]   = past_valid_q && prev_stb_q && prev_stall_q && i_wb_cyc
                                       && (!i_wb_stb || (req != prev_req_q));
            viol[VIOL_OPEN_NO_STB]   = past_valid_q && !prev_cyc_q && i_wb_cyc && !i_wb_stb;
            viol[VIOL_WR_NO_SEL]     = i_wb_stb && i_wb_we && (i_wb_sel == '0);
            viol[VIOL_IDLE_CYC]      = !OPT_RMW && i_wb_cyc && !i_wb_stb && (outstanding == '0);
            viol[VIOL_DISCONT_STB]   = !OPT_DISCONTINUOUS && past_valid_q && prev_cyc_q
                                       && !prev_stb_q && i_wb_stb;
            viol[VIOL_CYC_AFTER_ERR] = past_valid_q && prev_cyc_q && prev_err_q && i_wb_cyc;
            viol[VIOL_SPURIOUS_ACK]  = ((i_wb_ack || i_wb_err) && past_valid_q && !prev_cyc_q)
                                       || (i_wb_ack && (outstanding == '0));
            viol[VIOL_ACK_AND_ERR]   = i_wb_ack && i_wb_err;
            viol[VIOL_STALL_TIMEOUT] = stall_expired;
            viol[VIOL_ACK_TIMEOUT]   = ack_expired;
            viol[VIOL_OVERFLOW]      = accept && !i_wb_ack && !i_wb_err
                                       && (outstanding == {LGDEPTH{1'b1}});
        end
    end

    // A clear and a fresh violation in the same cycle: the fresh one re-latches.
    always_comb begin
        flags_d       = i_clear ? '0 : flags_q;
        first_d       = i_clear ? '0 : first_q;
        first_valid_d = i_clear ? 1'b0 : first_valid_q;
        flags_d       = flags_d | viol;
        if ((viol != '0) && !first_valid_d) begin
            first_d       = lowest_viol(viol);
            first_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            past_valid_q  <= 1'b0;
            prev_cyc_q    <= 1'b0;
            prev_stb_q    <= 1'b0;
            prev_stall_q  <= 1'b0;
            prev_err_q    <= 1'b0;
            prev_req_q    <= '0;
            nreqs_q       <= '0;
            nacks_q       <= '0;
            flags_q       <= '0;
            first_q       <= '0;
            first_valid_q <= 1'b0;
        end else begin
            past_valid_q  <= 1'b1;
            prev_cyc_q    <= i_wb_cyc;
            prev_stb_q    <= i_wb_stb;
            prev_stall_q  <= i_wb_stall;
            prev_err_q    <= i_wb_err;
            prev_req_q    <= req;
            nreqs_q       <= nreqs_d;
            nacks_q       <= nacks_d;
            flags_q       <= flags_d;
            first_q       <= first_d;
            first_valid_q <= first_valid_d;
        end
    end

    assign o_nreqs       = nreqs_q;
    assign o_nacks       = nacks_q;
    assign o_outstanding = outstanding;
    assign o_violation   = flags_q;
    assign o_first       = first_q;
    assign o_first_valid = first_valid_q;
    assign o_abort       = OPT_ABORT && !i_reset && i_wb_cyc && (stall_rose || ack_rose);

endmodule

// File: tb/tb_wb_protocol_monitor.sv
// Scoreboard bench for wb_protocol_monitor: directed bus scenarios followed by randomized
// traffic, with every cycle checked against a rule-level reference model.
module tb_wb_protocol_monitor;

    localparam int MaxStall = 4;
    localparam int MaxAck   = 10;

    typedef struct {
        logic        rst, cyc, stb, we;
        logic [31:0] addr, data;
        logic [3:0]  sel;
        logic        ack, err, stall, clr;
    } stim_t;

    typedef struct {
        logic [3:0]  outst;
        logic        abort;
        logic [3:0]  nreqs, nacks;
        logic [11:0] viol0, viol1;
        logic [3:0]  first0, first1;
        logic        fv0, fv1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we, ack, err, stall, clr;
    logic [31:0] addr, data;
    logic [3:0]  sel;

    logic [3:0]  d_nreqs, d_nacks, d_outst, d_first, r_nreqs, r_nacks, r_outst, r_first;
    logic [11:0] d_viol, r_viol;
    logic        d_fv, d_abort, r_fv, r_abort;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_abort = 0;

    // Reference model state
    int          m_nreqs = 0, m_nacks = 0, m_srun = 0, m_arun = 0;
    bit          m_pv = 1'b0;
    stim_t       m_prev;
    logic [11:0] m_flags[2];
    int          m_first[2];
    bit          m_fv[2];

    always #5 clk = ~clk;

    wb_protocol_monitor #(
        .MAX_STALL     (MaxStall),
        .MAX_ACK_DELAY (MaxAck)
    ) u_dut (
        .i_clk (clk), .i_reset (rst), .i_wb_cyc (cyc), .i_wb_stb (stb), .i_wb_we (we),
        .i_wb_addr (addr), .i_wb_data (data), .i_wb_sel (sel), .i_wb_ack (ack),
        .i_wb_stall (stall), .i_wb_err (err), .i_clear (clr),
        .o_nreqs (d_nreqs), .o_nacks (d_nacks), .o_outstanding (d_outst),
        .o_violation (d_viol), .o_first (d_first), .o_first_valid (d_fv), .o_abort (d_abort)
    );

    wb_protocol_monitor #(
        .MAX_STALL     (MaxStall),
        .MAX_ACK_DELAY (MaxAck),
        .OPT_RMW       (1'b1)
    ) u_dut_rmw (
        .i_clk (clk), .i_reset (rst), .i_wb_cyc (cyc), .i_wb_stb (stb), .i_wb_we (we),
        .i_wb_addr (addr), .i_wb_data (data), .i_wb_sel (sel), .i_wb_ack (ack),
        .i_wb_stall (stall), .i_wb_err (err), .i_clear (clr),
        .o_nreqs (r_nreqs), .o_nacks (r_nacks), .o_outstanding (r_outst),
        .o_violation (r_viol), .o_first (r_first), .o_first_valid (r_fv), .o_abort (r_abort)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] rules(input stim_t s, input int outst, input bit s_to,
                                          input bit a_to, input bit rmw);
        logic [11:0] r = '0;
        stim_t p = m_prev;
        r[0]  = s.stb && !s.cyc;
        r[1]  = m_pv && p.stb && p.stall && s.cyc && (!s.stb || s.we != p.we
                || s.addr != p.addr || s.data != p.data || s.sel != p.sel);
        r[2]  = m_pv && !p.cyc && s.cyc && !s.stb;
        r[3]  = s.stb && s.we && s.sel == 4'h0;
        r[4]  = !rmw && s.cyc && !s.stb && outst == 0;
        r[5]  = m_pv && p.cyc && !p.stb && s.stb;
        r[6]  = m_pv && p.cyc && p.err && s.cyc;
        r[7]  = ((s.ack || s.err) && m_pv && !p.cyc) || (s.ack && outst == 0);
        r[8]  = s.ack && s.err;
        r[9]  = s_to;
        r[10] = a_to;
        r[11] = s.cyc && s.stb && !s.stall && !s.ack && !s.err && outst == 15;
        return r;
    endfunction

    task automatic model(input stim_t s);
        exp_t        e;
        int          outst, srun_n, arun_n;
        bit          s_to, a_to, s_rose, a_rose, acc, ae;
        logic [11:0] v;
        outst  = s.cyc ? (m_nreqs - m_nacks + 16) % 16 : 0;
        acc    = s.cyc && s.stb && !s.stall;
        ae     = s.cyc && (s.ack || s.err);
        srun_n = (s.stb && s.stall) ? ((m_srun == MaxStall + 1) ? m_srun : m_srun + 1) : 0;
        arun_n = (s.cyc && !s.stb && !s.ack && !s.err && outst > 0)
               ? ((m_arun == MaxAck + 1) ? m_arun : m_arun + 1) : 0;
        s_to   = srun_n == MaxStall + 1;
        a_to   = arun_n == MaxAck + 1;
        s_rose = s_to && m_srun != MaxStall + 1;
        a_rose = a_to && m_arun != MaxAck + 1;
        e.outst = 4'(outst);
        e.abort = !s.rst && s.cyc && (s_rose || a_rose);
        for (int k = 0; k < 2; k++) begin
            v = s.rst ? 12'h0 : rules(s, outst, s_to, a_to, k == 1);
            if (s.rst || s.clr) begin
                m_flags[k] = 12'h0;
                m_first[k] = 0;
                m_fv[k]    = 1'b0;
            end
            m_flags[k] = m_flags[k] | v;
            if (v != 12'h0 && !m_fv[k]) begin
                for (int i = 0; i < 12; i++) begin
                    if (v[i]) begin
                        m_first[k] = i;
                        break;
                    end
                end
                m_fv[k] = 1'b1;
            end
        end
        if (s.rst || !s.cyc) begin
            m_nreqs = 0;
            m_nacks = 0;
        end else begin
            m_nreqs = (m_nreqs + int'(acc)) % 16;
            m_nacks = (m_nacks + int'(ae)) % 16;
        end
        m_srun = s.rst ? 0 : srun_n;
        m_arun = s.rst ? 0 : arun_n;
        m_pv   = !s.rst;
        m_prev = s;
        e.nreqs  = 4'(m_nreqs);
        e.nacks  = 4'(m_nacks);
        e.viol0  = m_flags[0];
        e.viol1  = m_flags[1];
        e.first0 = 4'(m_first[0]);
        e.first1 = 4'(m_first[1]);
        e.fv0    = m_fv[0];
        e.fv1    = m_fv[1];
        q.push_back(e);
    endtask

    task automatic step(input stim_t s);
        @(posedge clk);
        #2;
        rst = s.rst; cyc = s.cyc; stb = s.stb; we = s.we; addr = s.addr; data = s.data;
        sel = s.sel; ack = s.ack; err = s.err; stall = s.stall; clr = s.clr;
        model(s);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b0; s.cyc = 1'b0; s.stb = 1'b0; s.we = 1'b0; s.addr = '0; s.data = '0;
        s.sel = 4'hf; s.ack = 1'b0; s.err = 1'b0; s.stall = 1'b0; s.clr = 1'b0;
        return s;
    endfunction

    function automatic stim_t wr(input logic [31:0] a, input logic stl);
        stim_t s = idle();
        s.cyc = 1'b1; s.stb = 1'b1; s.we = 1'b1; s.addr = a; s.data = a ^ 32'ha5a5_0000;
        s.stall = stl;
        return s;
    endfunction

    function automatic stim_t bus(input logic a, input logic e, input logic c);
        stim_t s = idle();
        s.cyc = 1'b1; s.ack = a; s.err = e; s.clr = c;
        return s;
    endfunction

    function automatic bit pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    // Monitor: combinational outputs mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (d_abort === 1'b1) n_abort++;
                check("outstanding", 32'(d_outst), 32'(e.outst));
                check("abort", 32'(d_abort), 32'(e.abort));
                check("rmw_abort", 32'(r_abort), 32'(e.abort));
                @(posedge clk);
                #1;
                check("nreqs", 32'(d_nreqs), 32'(e.nreqs));
                check("nacks", 32'(d_nacks), 32'(e.nacks));
                check("violation", 32'(d_viol), 32'(e.viol0));
                check("first", 32'(d_first), 32'(e.first0));
                check("first_valid", 32'(d_fv), 32'(e.fv0));
                check("rmw_violation", 32'(r_viol), 32'(e.viol1));
                check("rmw_first", 32'(r_first), 32'(e.first1));
                check("rmw_first_valid", 32'(r_fv), 32'(e.fv1));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s, p;
        int    a0, ack_p, stall_p, stb_p;
        s = idle();
        s.rst = 1'b1;
        step(s);
        step(s);
        step(idle());
        check("reset_violation", 32'(d_viol), 32'h0);
        check("reset_first_valid", 32'(d_fv), 32'h0);
        check("reset_nreqs", 32'(d_nreqs), 32'h0);

        // Clean three-write burst, ACKs two clocks behind
        a0 = n_abort;
        step(wr(32'h0, 1'b0));
        step(wr(32'h4, 1'b0));
        s = wr(32'h8, 1'b0); s.ack = 1'b1; step(s);
        step(bus(1'b1, 1'b0, 1'b0));
        step(bus(1'b1, 1'b0, 1'b0));
        step(idle());
        check("burst_nreqs", 32'(d_nreqs), 32'd3);
        check("burst_nacks", 32'(d_nacks), 32'd3);
        check("burst_violation", 32'(d_viol), 32'h0);
        check("burst_aborts", 32'(n_abort - a0), 32'd0);

        // Five stalled cycles -> stall timeout, one abort pulse, then clear
        a0 = n_abort;
        for (int i = 0; i < 5; i++) step(wr(32'h20, 1'b1));
        step(wr(32'h20, 1'b0));
        check("stall_bit9", 32'(d_viol[9]), 32'd1);
        check("stall_first", 32'(d_first), 32'd9);
        step(bus(1'b1, 1'b0, 1'b1));
        step(idle());
        check("stall_cleared", 32'(d_viol), 32'h0);
        check("stall_aborts", 32'(n_abort - a0), 32'd1);

        // Address changes while stalled
        step(wr(32'h10, 1'b1));
        step(wr(32'h14, 1'b1));
        step(wr(32'h14, 1'b0));
        check("reqchg_bit1", 32'(d_viol[1]), 32'd1);
        check("reqchg_first", 32'(d_first), 32'd1);
        step(bus(1'b1, 1'b0, 1'b1));
        step(idle());

        // ACK and ERR together, then CYC held after ERR
        step(wr(32'h30, 1'b0));
        step(bus(1'b1, 1'b1, 1'b0));
        step(bus(1'b0, 1'b0, 1'b0));
        s = idle(); s.clr = 1'b1; step(s);
        check("ackerr_bit8", 32'(d_viol[8]), 32'd1);
        check("ackerr_bit6", 32'(d_viol[6]), 32'd1);
        check("ackerr_first", 32'(d_first), 32'd8);

        // Idle CYC with nothing outstanding: flagged unless OPT_RMW
        step(wr(32'h40, 1'b0));
        step(bus(1'b1, 1'b0, 1'b0));
        step(bus(1'b0, 1'b0, 1'b0));
        step(idle());
        check("idle_violation", 32'(d_viol), 32'h010);
        check("idle_rmw_violation", 32'(r_viol), 32'h0);
        s = idle(); s.clr = 1'b1; step(s);

        // Reset mid-burst, then a clear coinciding with a zero-select write
        step(wr(32'h50, 1'b0));
        step(wr(32'h54, 1'b0));
        s = bus(1'b0, 1'b0, 1'b0); s.rst = 1'b1; step(s);
        s = idle(); s.stb = 1'b1; step(s);
        check("midrst_nreqs", 32'(d_nreqs), 32'h0);
        check("midrst_nacks", 32'(d_nacks), 32'h0);
        check("midrst_violation", 32'(d_viol), 32'h0);
        s = wr(32'h58, 1'b0); s.sel = 4'h0; s.clr = 1'b1; step(s);
        step(bus(1'b1, 1'b0, 1'b0));
        check("clrsel_violation", 32'(d_viol), 32'h008);
        check("clrsel_first", 32'(d_first), 32'd3);
        step(idle());

        // Randomized traffic in segments with varying ack/stall/strobe densities
        p = idle();
        ack_p = 30; stall_p = 30; stb_p = 55;
        for (int n = 0; n < 800; n++) begin
            if (n % 40 == 0) begin
                case ($urandom_range(0, 2))
                    0: ack_p = 0;
                    1: ack_p = 10;
                    default: ack_p = 40;
                endcase
                case ($urandom_range(0, 2))
                    0: stall_p = 0;
                    1: stall_p = 30;
                    default: stall_p = 90;
                endcase
                stb_p = pct(50) ? 5 : 55;
            end
            s = idle();
            s.cyc = p.cyc ? pct(92) : pct(40);
            s.stb = s.cyc ? pct(stb_p) : pct(3);
            if (p.stb && p.stall && pct(85)) begin
                s.we = p.we; s.addr = p.addr; s.data = p.data; s.sel = p.sel;
            end else begin
                s.we   = pct(50);
                s.addr = 32'($urandom_range(0, 15)) << 2;
                s.data = $urandom;
                s.sel  = pct(12) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            s.stall = pct(stall_p);
            s.ack   = s.cyc ? pct(ack_p) : pct(2);
            s.err   = pct(3);
            s.clr   = pct(6);
            s.rst   = pct(1);
            step(s);
            p = s;
        end
        step(idle());

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
